// File: rtl/lane_deskew_fifo_if.sv
// Per-lane word path between block sync, the deskew FIFO and the lane collector.
//   in_data / in_data_valid / in_data_sync : received word from the descrambler
//   in_pop                                  : head pop request from the collector
//   out_canpop / out_issync / out_rxdata / out_rxdata_valid : FWFT head status
// master : upstream + collector side (drives in_*), slave : the deskew FIFO.
interface lane_deskew_fifo_if #(
    parameter int unsigned DATA_W = 64
);
    logic [DATA_W-1:0] in_data;
    logic              in_data_valid;
    logic              in_data_sync;
    logic              in_pop;
    logic              out_canpop;
    logic              out_issync;
    logic [DATA_W-1:0] out_rxdata;
    logic              out_rxdata_valid;

    modport master (
        output in_data, in_data_valid, in_data_sync, in_pop,
        input  out_canpop, out_issync, out_rxdata, out_rxdata_valid
    );

    modport slave (
        input  in_data, in_data_valid, in_data_sync, in_pop,
        output out_canpop, out_issync, out_rxdata, out_rxdata_valid
    );
endinterface

// File: rtl/lane_deskew_fifo.sv
// Per-lane deskew FIFO: buffers received words, qualifies them against periodic
// alignment markers and presents a first-word-fall-through head to the collector.
// Marker-spacing violations and overflow flush the buffer, pulse out_dissync and
// send the lane back to hunting for a marker.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   in_enable      : global clock enable, all state holds while low
//   in_block_lock  : block lock from block sync, low flushes and blocks writes
//   in_softreset   : flush request from the collector
//   bus            : word in / FWFT head out (lane_deskew_fifo_if.slave)
//   out_dissync    : one-cycle alignment-loss pulse
//   out_level      : current occupancy
//   out_aligned    : lane is locked to the marker grid
module lane_deskew_fifo #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned SYNC_PERIOD = 2048,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_enable,
    input  logic                  in_block_lock,
    input  logic                  in_softreset,
    lane_deskew_fifo_if.slave     bus,
    output logic                  out_dissync,
    output logic [DEPTH_LOG2:0]   out_level,
    output logic                  out_aligned
);
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;

    logic [DATA_W-1:0]  mem_data [DEPTH];
    logic               mem_sync [DEPTH];

    logic empty;
    logic full;
    logic at_end;
    logic flush_req;
    logic wr_en;
    logic pop_en;
    logic evt;

    // Occupancy flags: pointer MSB tells full from empty.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign at_end = (cnt == CNT_W'(SYNC_PERIOD - 1));
    assign flush_req = in_softreset || !in_block_lock;

    // Write qualification: a marker is legal exactly when the spacing counter
    // sits on the last slot of the period, a data word exactly when it does not.
    always_comb begin
        wr_en  = 1'b0;
        evt    = 1'b0;
        if (bus.in_data_valid) begin
            if (state == HUNT) begin
                wr_en = bus.in_data_sync;
            end else if (full && !bus.in_pop) begin
                evt = 1'b1;
            end else if (bus.in_data_sync == at_end) begin
                wr_en = 1'b1;
            end else begin
                evt = 1'b1;
            end
        end
        if (flush_req) begin
            wr_en = 1'b0;
            evt   = 1'b0;
        end
        pop_en = bus.in_pop && !empty && !flush_req && !evt;
    end

    // Control state, pointers, spacing counter and the dissync pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HUNT;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            out_dissync <= 1'b0;
        end else if (in_enable) begin
            out_dissync <= 1'b0;
            if (flush_req || evt) begin
                state       <= HUNT;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                cnt         <= '0;
                out_dissync <= evt;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    state  <= LOCKED;
                    cnt    <= bus.in_data_sync ? '0 : cnt + CNT_W'(1);
                end
                if (pop_en) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Entry storage is not reset; only the pointers qualify it.
    always_ff @(posedge clk) begin
        if (in_enable && wr_en) begin
            mem_data[wr_ptr[DEPTH_LOG2-1:0]] <= bus.in_data;
            mem_sync[wr_ptr[DEPTH_LOG2-1:0]] <= bus.in_data_sync;
        end
    end

    // FWFT head, decoded straight from the registered pointers.
    assign bus.out_rxdata       = mem_data[rd_ptr[DEPTH_LOG2-1:0]];
    assign bus.out_issync       = mem_sync[rd_ptr[DEPTH_LOG2-1:0]] && !empty;
    assign bus.out_canpop       = !empty;
    assign bus.out_rxdata_valid = !empty;
    assign out_level            = wr_ptr - rd_ptr;
    assign out_aligned          = (state == LOCKED);
endmodule

// File: tb/tb_lane_deskew_fifo.sv
// Directed bench for lane_deskew_fifo (SYNC_PERIOD=8, DEPTH_LOG2=2) with a
// queue-based reference model checked every cycle plus literal spot checks.
module tb_lane_deskew_fifo;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned DL2    = 2;
    localparam int unsigned SP     = 8;
    localparam int unsigned DEPTH  = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_enable = 1'b1;
    logic            in_block_lock = 1'b1;
    logic            in_softreset = 1'b0;
    logic            out_dissync;
    logic [DL2:0]    out_level;
    logic            out_aligned;

    lane_deskew_fifo_if #(.DATA_W(DATA_W)) bus ();

    lane_deskew_fifo #(
        .DATA_W(DATA_W), .DEPTH_LOG2(DL2), .SYNC_PERIOD(SP), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_enable(in_enable),
        .in_block_lock(in_block_lock), .in_softreset(in_softreset),
        .bus(bus), .out_dissync(out_dissync), .out_level(out_level),
        .out_aligned(out_aligned)
    );

    always #5 clk = ~clk;

    // Reference model: queue of {sync,data}, lock flag and words since marker.
    logic [DATA_W:0] mq[$];
    bit m_locked = 0;
    int m_pos = 0;
    bit m_dis = 0;
    bit m_ev, m_wr, m_pop;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete(); m_locked = 0; m_pos = 0; m_dis = 0;
        end else if (in_enable) begin
            m_dis = 0; m_ev = 0; m_wr = 0;
            if (in_softreset || !in_block_lock) begin
                mq.delete(); m_locked = 0; m_pos = 0;
            end else begin
                m_pop = bus.in_pop && (mq.size() > 0);
                if (bus.in_data_valid) begin
                    if (!m_locked) begin
                        if (bus.in_data_sync) begin m_wr = 1; m_locked = 1; m_pos = 1; end
                    end else if (mq.size() == DEPTH && !bus.in_pop) begin
                        m_ev = 1;
                    end else if (bus.in_data_sync) begin
                        if (m_pos == SP) begin m_wr = 1; m_pos = 1; end else m_ev = 1;
                    end else begin
                        if (m_pos < SP) begin m_wr = 1; m_pos++; end else m_ev = 1;
                    end
                end
                if (m_ev) begin
                    mq.delete(); m_locked = 0; m_pos = 0; m_dis = 1;
                end else begin
                    if (m_pop) void'(mq.pop_front());
                    if (m_wr) mq.push_back({bus.in_data_sync, bus.in_data});
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [DATA_W:0] h;
        chk("canpop", 64'(bus.out_canpop), 64'(mq.size() > 0));
        chk("rxvalid", 64'(bus.out_rxdata_valid), 64'(mq.size() > 0));
        chk("level", 64'(out_level), 64'(mq.size()));
        chk("aligned", 64'(out_aligned), 64'(m_locked));
        chk("dissync", 64'(out_dissync), 64'(m_dis));
        if (mq.size() > 0) begin
            h = mq[0];
            chk("issync", 64'(bus.out_issync), 64'(h[DATA_W]));
            chk("rxdata", bus.out_rxdata, h[DATA_W-1:0]);
        end else begin
            chk("issync", 64'(bus.out_issync), 64'(0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic drive(input bit v, input bit s, input logic [DATA_W-1:0] d, input bit p);
        bus.in_data_valid = v;
        bus.in_data_sync  = s;
        bus.in_data       = d;
        bus.in_pop        = p;
        tick();
    endtask

    task automatic idle(input int n, input bit p);
        for (int i = 0; i < n; i++) drive(0, 0, 64'h0, p);
    endtask

    task automatic soft_flush();
        in_softreset = 1'b1;
        idle(1, 0);
        in_softreset = 1'b0;
    endtask

    initial begin
        bus.in_data_valid = 0; bus.in_data_sync = 0; bus.in_data = '0; bus.in_pop = 0;
        #1;
        // Reset state
        chk("rst_canpop", 64'(bus.out_canpop), 64'(0));
        chk("rst_level", 64'(out_level), 64'(0));
        chk("rst_aligned", 64'(out_aligned), 64'(0));
        chk("rst_dissync", 64'(out_dissync), 64'(0));
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        idle(1, 0);

        // 1: hunt discards non-markers, marker locks
        for (int i = 0; i < 3; i++) drive(1, 0, 64'(16 + i), 0);
        drive(1, 1, 64'hA5, 0);
        chk("t1_canpop", 64'(bus.out_canpop), 64'(1));
        chk("t1_issync", 64'(bus.out_issync), 64'(1));
        chk("t1_rxdata", bus.out_rxdata, 64'hA5);
        chk("t1_level", 64'(out_level), 64'(1));
        chk("t1_aligned", 64'(out_aligned), 64'(1));

        // 2: full period streamed through with pop held high
        soft_flush();
        drive(1, 1, 64'h200, 1);
        for (int i = 1; i <= 7; i++) drive(1, 0, 64'(32'h200 + i), 1);
        drive(1, 1, 64'h2FF, 1);
        idle(3, 1);
        chk("t2_level", 64'(out_level), 64'(0));
        chk("t2_aligned", 64'(out_aligned), 64'(1));

        // 3: misplaced marker
        soft_flush();
        drive(1, 1, 64'h300, 0);
        for (int i = 1; i <= 3; i++) drive(1, 0, 64'(32'h300 + i), 0);
        drive(1, 1, 64'h3FF, 0);
        chk("t3_dissync", 64'(out_dissync), 64'(1));
        chk("t3_level", 64'(out_level), 64'(0));
        chk("t3_aligned", 64'(out_aligned), 64'(0));
        idle(1, 0);
        chk("t3_pulse_end", 64'(out_dissync), 64'(0));
        drive(1, 1, 64'h310, 0);
        chk("t3_relock", 64'(out_aligned), 64'(1));

        // 4: missing marker after 7 data words
        soft_flush();
        drive(1, 1, 64'h400, 1);
        for (int i = 1; i <= 8; i++) drive(1, 0, 64'(32'h400 + i), 1);
        chk("t4_dissync", 64'(out_dissync), 64'(1));
        chk("t4_canpop", 64'(bus.out_canpop), 64'(0));
        idle(1, 0);

        // 5: overflow, then full with simultaneous pop
        soft_flush();
        drive(1, 1, 64'h500, 0);
        for (int i = 1; i <= 3; i++) drive(1, 0, 64'(32'h500 + i), 0);
        chk("t5_full", 64'(out_level), 64'(4));
        drive(1, 0, 64'h504, 0);
        chk("t5_ovf_dissync", 64'(out_dissync), 64'(1));
        chk("t5_ovf_level", 64'(out_level), 64'(0));
        soft_flush();
        drive(1, 1, 64'h510, 0);
        for (int i = 1; i <= 3; i++) drive(1, 0, 64'(32'h510 + i), 0);
        drive(1, 0, 64'h514, 1);
        chk("t5_pop_dissync", 64'(out_dissync), 64'(0));
        chk("t5_pop_level", 64'(out_level), 64'(4));
        chk("t5_pop_head", bus.out_rxdata, 64'h511);
        // enable low: everything holds
        in_enable = 1'b0;
        drive(1, 0, 64'h515, 1);
        drive(1, 1, 64'h516, 1);
        chk("t5_hold_level", 64'(out_level), 64'(4));
        in_enable = 1'b1;

        // 6a: block lock lost for one cycle
        in_block_lock = 1'b0;
        drive(1, 0, 64'h600, 0);
        in_block_lock = 1'b1;
        chk("t6_lock_level", 64'(out_level), 64'(0));
        chk("t6_lock_dissync", 64'(out_dissync), 64'(0));
        chk("t6_lock_aligned", 64'(out_aligned), 64'(0));

        // 6b: soft reset mid-stream
        drive(1, 1, 64'h610, 0);
        drive(1, 0, 64'h611, 0);
        in_softreset = 1'b1;
        drive(1, 0, 64'h612, 1);
        in_softreset = 1'b0;
        chk("t6_soft_level", 64'(out_level), 64'(0));
        chk("t6_soft_dissync", 64'(out_dissync), 64'(0));

        // 6c: asynchronous reset mid-cycle
        drive(1, 1, 64'h620, 0);
        drive(1, 0, 64'h621, 0);
        bus.in_data_valid = 0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_arst_canpop", 64'(bus.out_canpop), 64'(0));
        chk("t6_arst_level", 64'(out_level), 64'(0));
        chk("t6_arst_aligned", 64'(out_aligned), 64'(0));
        @(negedge clk);
        compare_model();
        reset_n = 1'b1;
        idle(2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lane_deskew_fifo.md
Name: lane_deskew_fifo

Overview:
- One instance per lane, between that lane's block-sync/descrambler output and the lane collector.
- Buffers received words, qualifies them against periodic alignment (sync) markers, and presents first-word-fall-through (FWFT) head status to the collector: canpop, issync and data.
- The collector pops selected lanes to deskew them.
- Detects marker-spacing violations and overflow, pulses dissync, and then re-hunts for alignment.

Parameters:
- DATA_W, 64: word width (equals `UNITWIDTH).
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 entries.
- SYNC_PERIOD, 2048: marker spacing in words, counting the marker itself.
- CNT_W, 16: spacing counter width; must satisfy SYNC_PERIOD <= 2**CNT_W.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_enable  in  1  global clock enable; when low all state holds.
- in_block_lock  in  1  lane block lock from block sync.
- in_softreset  in  1  flush request from collector.
- in_data  in  DATA_W  received word.
- in_data_valid  in  1  in_data qualifier.
- in_data_sync  in  1  in_data is an alignment marker.
- in_pop  in  1  pop head entry (from collector).
- out_canpop  out  1  FIFO non-empty.
- out_issync  out  1  head entry is a marker.
- out_rxdata  out  DATA_W  head entry data.
- out_rxdata_valid  out  1  head data valid (equals out_canpop).
- out_dissync  out  1  one-cycle alignment-loss pulse.
- out_level  out  DEPTH_LOG2+1  current occupancy.
- out_aligned  out  1  state is LOCKED.

Behaviour:

Reset and enable
- reset_n is asynchronous and active-low.
- On reset: pointers = 0, level = 0, state = HUNT, spacing counter = 0, out_dissync = 0. Hence out_canpop = 0, out_issync = 0, out_rxdata_valid = 0, out_aligned = 0.
- out_rxdata after reset is don't-care (storage is not reset).
- All sequential updates are gated by in_enable. With in_enable low, nothing changes and the outputs hold.

Storage
- Circular buffer with (DEPTH_LOG2+1)-bit read/write pointers; the MSB disambiguates full from empty.
- Each entry holds {sync, data}.
- FWFT head outputs:
  - out_rxdata = data[rd]
  - out_issync = sync[rd] AND non-empty
  - out_canpop = out_rxdata_valid = non-empty
  - These are combinational from registers, so there is zero cycle latency from a write to canpop after the pointer update. A written word is visible at the head the cycle after the write.
- Pop: in_pop AND non-empty advances rd. in_pop while empty is ignored.

Write-side state machine (evaluated when in_enable AND in_data_valid)
- HUNT:
  - Non-marker words are discarded.
  - A marker is written, counter := 0, next state LOCKED.
- LOCKED, non-marker word:
  - If counter == SYNC_PERIOD-1 (missing marker): event.
  - Otherwise write the word and counter := counter + 1.
- LOCKED, marker word:
  - If counter == SYNC_PERIOD-1: write the marker and counter := 0.
  - Otherwise (misplaced marker): event.
- LOCKED, FIFO full with no pop in the same cycle (overflow): event.
  - Full with a simultaneous pop is not overflow; the write proceeds and the level is unchanged.

Event handling
- The word is dropped.
- Next cycle: rd = wr = 0, state = HUNT, out_dissync = 1 for exactly one cycle (registered).
- Pops in the event cycle are discarded by the flush.

Loss of lock and soft reset
- in_block_lock low: flush and enter HUNT. No dissync pulse. Writes are blocked while it is low.
- in_softreset high: flush and enter HUNT. No dissync pulse. It overrides writes and pops in that cycle.

Priority and level
- Priority: in_softreset > !in_block_lock > event > normal write/pop.
- out_level = wr - rd, with modulo arithmetic on the pointer width.

Test Plan:
Bench parameters: SYNC_PERIOD=8, DEPTH_LOG2=2, DATA_W=64, in_block_lock=1, in_enable=1 unless stated otherwise.

1. Reset, then 3 non-marker words, then a marker with data 0xA5, no pops.
   -> The first 3 words are dropped. One cycle after the marker write: out_canpop=1, out_issync=1, out_rxdata=0xA5, out_level=1, out_aligned=1.
2. Marker, 7 data words, marker, with in_pop held high.
   -> All 9 words are popped in order. out_issync is high only on the two marker heads. out_dissync stays 0.
3. Marker, then a second marker after 3 data words.
   -> out_dissync pulses for 1 cycle. out_level=0, out_canpop=0, out_aligned=0. The next valid marker re-locks.
4. Marker, then 8 data words.
   -> The 8th data word triggers the missing-marker event and a dissync pulse; the FIFO flushes.
5. With in_pop=0, write marker + 4 words.
   -> After 4 entries (full), the 5th write gives overflow: dissync pulse, flush.
   -> Repeat with in_pop=1 on the 5th write: no dissync, out_level stays 4.
6. Mid-stream, drop in_block_lock for 1 cycle, or assert in_softreset, or assert reset_n=0 asynchronously mid-cycle.
   -> The FIFO empties with no dissync pulse, state returns to HUNT, and reset clears the outputs immediately without waiting for a clock edge.
